// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and defaults for the carry-save accumulator controller
package csa_pkg;

  // Controller states, fixed encoding so waveforms read consistently across builds
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCUM   = 2'b01,
    RESOLVE = 2'b10,
    DONE    = 2'b11
  } csa_state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ACC_W   = 12;
  localparam int DEF_MAX_OPS = 16;

  // Width of one slice of the serial carry-propagate add
  localparam int NIB_W = 4;

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// rtl/csa_accum_ctrl_if.sv - operand and result handshakes of the accumulator controller
interface csa_accum_ctrl_if #(
  parameter int WIDTH = csa_pkg::DEF_WIDTH,
  parameter int ACC_W = csa_pkg::DEF_ACC_W,
  parameter int CNT_W = $clog2(csa_pkg::DEF_MAX_OPS) + 1
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_err;

  // Producer of operands and consumer of results
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_err
  );

  // The accumulator controller itself
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_err
  );

endinterface

// File: rtl/csa_3to2_row.sv
// rtl/csa_3to2_row.sv - one row of full adders compressing three vectors into sum and carry
module csa_3to2_row import csa_pkg::*; #(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic [ACC_W-1:0] c,
  output logic [ACC_W-1:0] s,
  output logic [ACC_W-1:0] c_shifted
);

  logic [ACC_W-1:0] maj;

  // Bitwise full add: parity is the sum, majority moves up one weight as carry
  always_comb begin
    s         = a ^ b ^ c;
    maj       = (a & b) | (a & c) | (b & c);
    c_shifted = maj << 1;
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// rtl/csa_accum_ctrl.sv - multi-operand carry-save accumulator with nibble-serial resolve
module csa_accum_ctrl import csa_pkg::*; #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_OPS = DEF_MAX_OPS
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_accum_ctrl_if.slave   bus
);

  localparam int CNT_W     = $clog2(MAX_OPS) + 1;
  localparam int NUM_NIB   = ACC_W / NIB_W;
  localparam int NIB_IDX_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;

  csa_state_t           state;
  logic [ACC_W-1:0]     sv;
  logic [ACC_W-1:0]     cv;
  logic [ACC_W-1:0]     res;
  logic [CNT_W-1:0]     cnt;
  logic [NIB_IDX_W-1:0] nib;
  logic                 carry_r;
  logic                 err_r;
  logic                 in_ready_r;
  logic                 out_valid_r;

  logic                 accept;
  logic [ACC_W-1:0]     op;
  logic [ACC_W-1:0]     row_a;
  logic [ACC_W-1:0]     row_b;
  logic [ACC_W-1:0]     row_s;
  logic [ACC_W-1:0]     row_c;
  logic [CNT_W-1:0]     cnt_next;
  logic                 hit_max;
  logic [NIB_W-1:0]     nib_s;
  logic [NIB_W-1:0]     nib_c;
  logic [NIB_W:0]       nib_sum;
  logic                 last_nib;

  // Accept qualification, first-operand clearing and the current resolve slice
  always_comb begin
    accept   = bus.in_valid && in_ready_r;
    op       = ACC_W'(bus.in_data);
    row_a    = (state == IDLE) ? '0 : sv;
    row_b    = (state == IDLE) ? '0 : cv;
    cnt_next = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
    hit_max  = (cnt_next == CNT_W'(MAX_OPS));
    nib_s    = '0;
    nib_c    = '0;
    for (int i = 0; i < NUM_NIB; i++) begin
      if (nib == NIB_IDX_W'(i)) begin
        nib_s = sv[i*NIB_W +: NIB_W];
        nib_c = cv[i*NIB_W +: NIB_W];
      end
    end
    nib_sum  = {1'b0, nib_s} + {1'b0, nib_c} + {{NIB_W{1'b0}}, carry_r};
    last_nib = (nib == NIB_IDX_W'(NUM_NIB - 1));
  end

  csa_3to2_row #(
    .ACC_W (ACC_W)
  ) u_row (
    .a         (row_a),
    .b         (row_b),
    .c         (op),
    .s         (row_s),
    .c_shifted (row_c)
  );

  // Controller: accumulate, resolve one nibble per cycle, then hold the result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      sv          <= '0;
      cv          <= '0;
      res         <= '0;
      cnt         <= '0;
      nib         <= '0;
      carry_r     <= 1'b0;
      err_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            sv  <= row_s;
            cv  <= row_c;
            cnt <= cnt_next;
            if (bus.in_last || hit_max) begin
              state      <= RESOLVE;
              in_ready_r <= 1'b0;
              err_r      <= !bus.in_last;
            end else begin
              state <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          for (int i = 0; i < NUM_NIB; i++) begin
            if (nib == NIB_IDX_W'(i)) begin
              res[i*NIB_W +: NIB_W] <= nib_sum[NIB_W-1:0];
            end
          end
          carry_r <= nib_sum[NIB_W];
          nib     <= nib + NIB_IDX_W'(1);
          if (last_nib) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            err_r       <= 1'b0;
            nib         <= '0;
            carry_r     <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result fields come straight from their holding registers
  always_comb begin
    bus.in_ready  = in_ready_r;
    bus.out_valid = out_valid_r;
    bus.out_sum   = res;
    bus.out_count = cnt;
    bus.out_err   = err_r;
  end

endmodule
